// File: rtl/byte_mem_rw.sv
// rtl/byte_mem_rw.sv - byte-addressed scratch memory with little-endian multi-byte access
// Ports:
//   Clk      rising-edge clock
//   rst      synchronous active-high reset (pipeline and flags only, not the array)
//   wr, rd   write / read request, one per cycle
//   in_add   byte start address, any alignment
//   be       per-byte write enables, bit i gates Data_in[8i+7:8i]
//   Data_in  write data, byte in_add in the LSBs
//   Data_out registered read data, 0 whenever valid is low
//   valid    Data_out holds a completed read
//   err      one-cycle pulse for a rejected request
module byte_mem_rw #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [ADDR_W-1:0]       in_add,
  input  logic [WORD_BYTES-1:0]   be,
  input  logic [8*WORD_BYTES-1:0] Data_in,
  output logic [8*WORD_BYTES-1:0] Data_out,
  output logic                    valid,
  output logic                    err
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = ADDR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic             in_range;
  logic             wr_ok;
  logic             rd_ok;
  logic             reject;
  logic [IDX_W-1:0] lane_idx [WORD_BYTES];
  logic [DW-1:0]    rd_word;
  logic [DW-1:0]    pipe_data [RD_LAT];
  logic             pipe_vld  [RD_LAT];

  // Range check is done one bit wider than the address so in_add + WORD_BYTES
  // cannot wrap and sneak a high address back into range.
  always_comb begin
    in_range = (({1'b0, in_add} + SW'(WORD_BYTES)) <= SW'(DEPTH));
    wr_ok    = wr && !rd && in_range && !rst;
    rd_ok    = rd && !wr && in_range && !rst;
    reject   = (wr && rd) || ((wr ^ rd) && !in_range);
  end

  // Per-lane byte index; truncation is safe because lanes are only used
  // when the whole access lies inside the array.
  always_comb begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      lane_idx[i] = IDX_W'(in_add + ADDR_W'(i));
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rd_word[8*i +: 8] = mem[lane_idx[i]];
    end
  end

  // Array has no reset: contents survive rst by design.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (wr_ok && be[i]) begin
        mem[lane_idx[i]] <= Data_in[8*i +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures at the request edge, last stage drives
  // the outputs. Bubbles carry zero data so Data_out is 0 while valid is low.
  always_ff @(posedge Clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_vld[s]  <= 1'b0;
        pipe_data[s] <= '0;
      end
      err <= 1'b0;
    end else begin
      pipe_vld[0]  <= rd_ok;
      pipe_data[0] <= rd_ok ? rd_word : '0;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_data[s] <= pipe_data[s-1];
      end
      err <= reject;
    end
  end

  assign Data_out = pipe_data[RD_LAT-1];
  assign valid    = pipe_vld[RD_LAT-1];

endmodule

// File: tb/tb_byte_mem_rw.sv
// tb/tb_byte_mem_rw.sv - directed table-driven bench for byte_mem_rw
module tb_byte_mem_rw;

  logic Clk;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // u1: W=4 D=16 RD_LAT=1
  logic        r1_rst, r1_wr, r1_rd;
  logic [3:0]  r1_add, r1_be;
  logic [31:0] r1_din, r1_dout;
  logic        r1_valid, r1_err;

  // u3: W=4 D=16 RD_LAT=3
  logic        r3_rst, r3_wr, r3_rd;
  logic [3:0]  r3_add, r3_be;
  logic [31:0] r3_din, r3_dout;
  logic        r3_valid, r3_err;

  // u8: W=8 D=64 ADDR_W=6 RD_LAT=2
  logic        r8_rst, r8_wr, r8_rd;
  logic [5:0]  r8_add;
  logic [7:0]  r8_be;
  logic [63:0] r8_din, r8_dout;
  logic        r8_valid, r8_err;

  byte_mem_rw u1 (
    .Clk(Clk), .rst(r1_rst), .wr(r1_wr), .rd(r1_rd), .in_add(r1_add), .be(r1_be),
    .Data_in(r1_din), .Data_out(r1_dout), .valid(r1_valid), .err(r1_err)
  );

  byte_mem_rw #(.WORD_BYTES(4), .DEPTH(16), .ADDR_W(4), .RD_LAT(3)) u3 (
    .Clk(Clk), .rst(r3_rst), .wr(r3_wr), .rd(r3_rd), .in_add(r3_add), .be(r3_be),
    .Data_in(r3_din), .Data_out(r3_dout), .valid(r3_valid), .err(r3_err)
  );

  byte_mem_rw #(.WORD_BYTES(8), .DEPTH(64), .ADDR_W(6), .RD_LAT(2)) u8 (
    .Clk(Clk), .rst(r8_rst), .wr(r8_wr), .rd(r8_rd), .in_add(r8_add), .be(r8_be),
    .Data_in(r8_din), .Data_out(r8_dout), .valid(r8_valid), .err(r8_err)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [3:0]  add;
    logic [3:0]  be;
    logic [31:0] din;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  vec_t vt [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rst, logic wr, logic rd, logic [3:0] add,
                              logic [3:0] be, logic [31:0] din,
                              logic ev, logic [31:0] ed, logic ee);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.add = add; v.be = be; v.din = din;
    v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic s3(logic rst, logic wr, logic rd, logic [3:0] add, logic [3:0] be, logic [31:0] din);
    r3_rst = rst; r3_wr = wr; r3_rd = rd; r3_add = add; r3_be = be; r3_din = din;
    @(posedge Clk);
    #1;
  endtask

  task automatic s8(logic rst, logic wr, logic rd, logic [5:0] add, logic [7:0] be, logic [63:0] din);
    r8_rst = rst; r8_wr = wr; r8_rd = rd; r8_add = add; r8_be = be; r8_din = din;
    @(posedge Clk);
    #1;
  endtask

  logic        p_rd   [8];
  logic [3:0]  p_add  [8];
  logic        p_ev   [8];
  logic [31:0] p_ed   [8];

  initial begin
    r1_rst = 1'b1; r1_wr = 1'b0; r1_rd = 1'b0; r1_add = '0; r1_be = '0; r1_din = '0;
    r3_rst = 1'b1; r3_wr = 1'b0; r3_rd = 1'b0; r3_add = '0; r3_be = '0; r3_din = '0;
    r8_rst = 1'b1; r8_wr = 1'b0; r8_rd = 1'b0; r8_add = '0; r8_be = '0; r8_din = '0;

    //           rst wr rd add be     din           ev  ed            ee
    vt.push_back(mk(1, 0, 0, 0,  4'h0, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 1, 0, 0,  4'hF, 32'hDEADBEEF, 0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 0,  4'h0, 32'h0,        1, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 1, 0, 4,  4'hF, 32'h44332211, 0, 32'h0,        0));
    vt.push_back(mk(0, 1, 0, 8,  4'hF, 32'h88776655, 0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 5,  4'h0, 32'h0,        1, 32'h55443322, 0));
    vt.push_back(mk(0, 1, 0, 4,  4'h5, 32'hAABBCCDD, 0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 4,  4'h0, 32'h0,        1, 32'h44BB22DD, 0));
    vt.push_back(mk(0, 1, 0, 12, 4'hF, 32'hC3C2C1C0, 0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 12, 4'h0, 32'h0,        1, 32'hC3C2C1C0, 0));
    vt.push_back(mk(0, 0, 1, 13, 4'h0, 32'h0,        0, 32'h0,        1));
    vt.push_back(mk(0, 1, 0, 15, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        1));
    vt.push_back(mk(0, 0, 1, 12, 4'h0, 32'h0,        1, 32'hC3C2C1C0, 0));
    vt.push_back(mk(0, 1, 1, 0,  4'hF, 32'h12345678, 0, 32'h0,        1));
    vt.push_back(mk(0, 0, 1, 0,  4'h0, 32'h0,        1, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 1, 0, 0,  4'h0, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 0,  4'h0, 32'h0,        1, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 1, 0, 0,  4'h3, 32'h0000CAFE, 0, 32'h0,        0));
    vt.push_back(mk(1, 0, 1, 0,  4'h0, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 0,  4'h0, 32'h0,        1, 32'hDEADCAFE, 0));
    vt.push_back(mk(1, 1, 0, 0,  4'hF, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 0,  4'h0, 32'h0,        1, 32'hDEADCAFE, 0));
    vt.push_back(mk(0, 0, 1, 8,  4'h0, 32'h0,        1, 32'h88776655, 0));
    vt.push_back(mk(0, 0, 1, 14, 4'h0, 32'h0,        0, 32'h0,        1));
    vt.push_back(mk(0, 0, 0, 0,  4'h0, 32'h0,        0, 32'h0,        0));
    vt.push_back(mk(0, 0, 1, 13, 4'h0, 32'h0,        0, 32'h0,        1));
    vt.push_back(mk(1, 0, 0, 0,  4'h0, 32'h0,        0, 32'h0,        0));

    for (int i = 0; i < vt.size(); i++) begin
      r1_rst = vt[i].rst; r1_wr = vt[i].wr; r1_rd = vt[i].rd;
      r1_add = vt[i].add; r1_be = vt[i].be; r1_din = vt[i].din;
      @(posedge Clk);
      #1;
      chk($sformatf("u1 v%0d Data_out", i), 64'(r1_dout), 64'(vt[i].ed));
      chk($sformatf("u1 v%0d valid", i), 64'(r1_valid), 64'(vt[i].ev));
      chk($sformatf("u1 v%0d err", i), 64'(r1_err), 64'(vt[i].ee));
    end
    r1_rst = 1'b0; r1_wr = 1'b0; r1_rd = 1'b0;

    // RD_LAT=3: fill, then pipelined reads with an idle gap
    s3(1, 0, 0, 0, 4'h0, 32'h0);
    chk("u3 reset valid", 64'(r3_valid), 64'd0);
    chk("u3 reset Data_out", 64'(r3_dout), 64'd0);
    s3(0, 1, 0, 0, 4'hF, 32'h03020100);
    s3(0, 1, 0, 4, 4'hF, 32'h07060504);
    s3(0, 1, 0, 8, 4'hF, 32'h0B0A0908);

    p_rd  = '{1, 1, 1, 0, 1, 0, 0, 0};
    p_add = '{0, 4, 8, 0, 0, 0, 0, 0};
    p_ev  = '{0, 0, 1, 1, 1, 0, 1, 0};
    p_ed  = '{32'h0, 32'h0, 32'h03020100, 32'h07060504, 32'h0B0A0908,
              32'h0, 32'h03020100, 32'h0};
    for (int n = 0; n < 8; n++) begin
      s3(0, 0, p_rd[n], p_add[n], 4'h0, 32'h0);
      chk($sformatf("u3 pipe s%0d valid", n), 64'(r3_valid), 64'(p_ev[n]));
      chk($sformatf("u3 pipe s%0d Data_out", n), 64'(r3_dout), 64'(p_ed[n]));
    end

    // err latency is one cycle regardless of RD_LAT
    s3(0, 1, 1, 0, 4'hF, 32'hFFFFFFFF);
    chk("u3 wr+rd err", 64'(r3_err), 64'd1);
    s3(0, 0, 0, 0, 4'h0, 32'h0);
    chk("u3 err single pulse", 64'(r3_err), 64'd0);
    for (int n = 0; n < 2; n++) begin
      s3(0, 0, 0, 0, 4'h0, 32'h0);
      chk($sformatf("u3 wr+rd bubble s%0d", n), 64'(r3_valid), 64'd0);
    end

    // reset one cycle after a read: it must never complete
    s3(0, 0, 1, 0, 4'h0, 32'h0);
    s3(1, 0, 0, 0, 4'h0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      s3(0, 0, 0, 0, 4'h0, 32'h0);
      chk($sformatf("u3 flushed s%0d valid", n), 64'(r3_valid), 64'd0);
      chk($sformatf("u3 flushed s%0d Data_out", n), 64'(r3_dout), 64'd0);
    end
    s3(0, 0, 1, 0, 4'h0, 32'h0);
    s3(0, 0, 0, 0, 4'h0, 32'h0);
    chk("u3 post-reset early valid", 64'(r3_valid), 64'd0);
    s3(0, 0, 0, 0, 4'h0, 32'h0);
    chk("u3 post-reset valid", 64'(r3_valid), 64'd1);
    chk("u3 post-reset Data_out", 64'(r3_dout), 64'h03020100);

    // 8-byte words, RD_LAT=2, top-of-array boundary
    s8(1, 0, 0, 0, 8'h00, 64'h0);
    s8(0, 1, 0, 56, 8'hFF, 64'h0807060504030201);
    chk("u8 write no valid", 64'(r8_valid), 64'd0);
    chk("u8 write no err", 64'(r8_err), 64'd0);
    s8(0, 0, 1, 56, 8'h00, 64'h0);
    chk("u8 read lat1 valid", 64'(r8_valid), 64'd0);
    s8(0, 0, 0, 0, 8'h00, 64'h0);
    chk("u8 read valid", 64'(r8_valid), 64'd1);
    chk("u8 read Data_out", r8_dout, 64'h0807060504030201);
    s8(0, 0, 1, 57, 8'h00, 64'h0);
    chk("u8 oor err", 64'(r8_err), 64'd1);
    s8(0, 0, 0, 0, 8'h00, 64'h0);
    chk("u8 oor err clears", 64'(r8_err), 64'd0);
    chk("u8 oor valid", 64'(r8_valid), 64'd0);
    chk("u8 oor Data_out", r8_dout, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
